// File: rtl/data_mem_reader_pkg.sv
// data_mem_reader_pkg: shared CPU memory access-type encodings and address helpers
package data_mem_reader_pkg;

    localparam logic [2:0] RW_LB  = 3'b000;
    localparam logic [2:0] RW_LH  = 3'b001;
    localparam logic [2:0] RW_LW  = 3'b010;
    localparam logic [2:0] RW_LBU = 3'b100;
    localparam logic [2:0] RW_LHU = 3'b101;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/data_mem_reader.sv
// data_mem_reader: streams a burst of words from data memory out over a valid/ready port
module data_mem_reader
    import data_mem_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    output logic        R_en,
    output logic        W_en,
    output logic [31:0] ram_addr,
    output logic [2:0]  RW_type,
    input  logic [31:0] Rd_mem_data,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_ram_addr;
    logic [15:0] r_rem;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_last;

    // ram_addr is its own register so it holds its value after the final increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_ram_addr <= '0;
            r_rem      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && word_count != 16'd0) begin
                        r_addr     <= word_align(base_addr);
                        r_ram_addr <= word_align(base_addr);
                        r_rem      <= word_count;
                        r_state    <= S_READ;
                    end else if (start) begin
                        r_state <= S_FIN;
                    end
                end
                S_READ: begin
                    r_data  <= Rd_mem_data;
                    r_valid <= 1'b1;
                    r_last  <= (r_rem == 16'd1);
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_rem   <= r_rem - 16'd1;
                        r_addr  <= r_addr + 32'd4;
                        if (!r_last)
                            r_ram_addr <= r_addr + 32'd4;
                        r_state <= r_last ? S_FIN : S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign R_en     = (r_state == S_READ);
    assign W_en     = 1'b0;
    assign ram_addr = r_ram_addr;
    assign RW_type  = RW_LW;
    assign m_data   = r_data;
    assign m_valid  = r_valid;
    assign m_last   = r_last;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);

endmodule

// File: tb/tb_data_mem_reader.sv
// tb_data_mem_reader: table-driven and randomized bursts checked against an address/data model
module tb_data_mem_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        R_en, W_en, m_valid, m_last, busy, done;
    logic [31:0] ram_addr, m_data, Rd_mem_data;
    logic [2:0]  RW_type;
    logic        m_ready = 1'b0;
    int          total = 0;
    int          bad = 0;

    data_mem_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .R_en(R_en), .W_en(W_en), .ram_addr(ram_addr), .RW_type(RW_type),
        .Rd_mem_data(Rd_mem_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h40 ? 32'h11111111 :
               a == 32'h44 ? 32'h22222222 :
               a == 32'h48 ? 32'h33333333 : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign Rd_mem_data = mem(ram_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ren", {31'd0, R_en}, 0);
        chk("rst_wen", {31'd0, W_en}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rwtype", {29'd0, RW_type}, 32'd2);
        chk("rst_mdata", m_data, 0);
        chk("rst_mvalid", {31'd0, m_valid}, 0);
        chk("rst_mlast", {31'd0, m_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall word 2 for five cycles
    task automatic burst(input logic [31:0] b, input int n, input int mode, input int inj, input int exp_done);
        int rd = 0, acc = 0, t = 0, busy_n = 0, stall = 0;
        logic pv = 1'b0, phs = 1'b0, pl = 1'b0, got = 1'b0;
        logic [31:0] pd = '0;
        logic [31:0] ab = b & ~32'd3;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n[15:0]; m_ready = 1'b0;
        while (!got && t < 300) begin
            @(posedge clk); #1;
            start = 1'b0;
            t++;
            if (inj != 0 && t == 3) begin
                start = 1'b1; base_addr = 32'h1000; word_count = 16'd9;
            end
            m_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                      (m_valid && acc == 1 && stall < 5) ? 1'b0 : 1'b1;
            if (mode == 2 && m_valid && acc == 1 && !m_ready) stall++;
            @(negedge clk);
            if (pv && !phs) begin
                chk("valid_held", {31'd0, m_valid}, 1);
                chk("data_held", m_data, pd);
                chk("last_held", {31'd0, m_last}, {31'd0, pl});
            end
            if (busy) busy_n++;
            if (R_en) begin
                chk("ram_addr", ram_addr, ab + 32'(rd) * 32'd4);
                chk("ren_while_valid", {31'd0, m_valid}, 0);
                rd++;
            end
            if (m_valid && m_ready) begin
                chk("m_data", m_data, mem(ab + 32'(acc) * 32'd4));
                chk("m_last", {31'd0, m_last}, acc == n - 1 ? 32'd1 : 32'd0);
                acc++;
            end
            pv = m_valid; phs = m_valid && m_ready; pd = m_data; pl = m_last;
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 1);
        chk("reads", rd, n);
        chk("words", acc, n);
        chk("busy_cycles", busy_n, t);
        chk("wen", {31'd0, W_en}, 0);
        chk("rwtype", {29'd0, RW_type}, 32'd2);
        if (mode == 2) chk("stall_cycles", stall, 5);
        if (exp_done >= 0) chk("done_time", t, exp_done);
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("idle_after", {31'd0, busy}, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          mode;
        int          inj;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h40, 3, 0, 0, 7};
        vecs[1] = '{32'h40, 3, 2, 0, -1};
        vecs[2] = '{32'h40, 0, 0, 0, 1};
        vecs[3] = '{32'hFFFFFFFE, 2, 0, 0, 5};
        vecs[4] = '{32'h40, 3, 0, 1, 7};
        vecs[5] = '{32'h123, 5, 0, 0, 11};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        for (int i = 0; i < 6; i++)
            burst(vecs[i].base, vecs[i].n, vecs[i].mode, vecs[i].inj, vecs[i].exp_done);
        for (int i = 0; i < 10; i++)
            burst($urandom, int'($urandom_range(0, 6)), 1, 0, -1);
        // abort a four-word burst while the first word waits for the sink
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h40; word_count = 16'd4; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_reached", {31'd0, m_valid}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'd0, done}, 0);
        end
        burst(32'h40, 1, 0, 0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_reader.md
DATA_MEM_READER -- requirements
Module: data_mem_reader

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 base_addr  input  32  byte address of first word; bits [1:0] ignored (treated as 0).
REQ-006 word_count  input  16  number of words to read; 0 is legal.
REQ-007 R_en  output  1  data-memory read enable.
REQ-008 W_en  output  1  data-memory write enable; constant 0.
REQ-009 ram_addr  output  32  data-memory byte address.
REQ-010 RW_type  output  3  access type; constant 3'b010 (word).
REQ-011 Rd_mem_data  input  32  data-memory read data, combinationally valid in the same cycle as R_en/ram_addr.
REQ-012 m_data  output  32  streamed word.
REQ-013 m_valid  output  1  m_data holds a word not yet accepted.
REQ-014 m_ready  input  1  sink accepts when m_valid and m_ready are both high on a rising edge.
REQ-015 m_last  output  1  high with m_valid on the final word of the burst.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when the burst completes.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, HOLD and FIN.
REQ-019 IDLE: on start with word_count != 0, latch addr = {base_addr[31:2],2'b00} and remaining = word_count, then go to READ; on start with word_count == 0, go to FIN with no memory access.
REQ-020 READ: R_en = 1 and ram_addr = addr for exactly one cycle; at the clock edge, latch m_data = Rd_mem_data, set m_valid = 1, set m_last = (remaining == 1), then go to HOLD.
REQ-021 HOLD: hold m_data, m_valid and m_last stable while m_ready = 0.
REQ-022 HOLD, on handshake: m_valid -> 0, remaining decrements, addr increments by 4 (mod 2^32, wrap-around permitted); go to FIN if m_last was set, otherwise to READ.
REQ-023 FIN: done = 1 for one cycle, then go to IDLE.
REQ-024 Latency: first R_en occurs 1 cycle after start; m_valid rises 2 cycles after start; sustained throughput is 1 word per 2 cycles with m_ready held high.
REQ-025 R_en SHALL be 0 in every state except READ; ram_addr SHALL hold its last value outside READ.
REQ-026 start while busy SHALL be ignored, with no effect on addr, remaining or the FSM.
REQ-027 m_valid SHALL never deassert without a handshake, except on rst.
REQ-028 m_ready while m_valid = 0 SHALL have no effect.

Reset
REQ-029 On rst, go to IDLE and force R_en = 0, W_en = 0, ram_addr = 0, RW_type = 3'b010, m_data = 0, m_valid = 0, m_last = 0, busy = 0, done = 0, remaining = 0.
REQ-030 rst asserted mid-burst SHALL abort the burst with no done pulse; the next start begins a fresh burst.

Structure
REQ-031 The RW_type encodings (LB 000, LH 001, LW 010, LBU 100, LHU 101) SHALL be defined in the shared CPU package, and this block SHALL use the LW constant from it.
REQ-032 The FSM state encoding SHALL be local to this module.
REQ-033 SHALL be a single module; no sub-module is natural, and the address and count registers are inline.

Verification
REQ-034 Memory holds 0x11111111, 0x22222222, 0x33333333 at 0x40, 0x44, 0x48; stimulus: start, base_addr = 0x40, word_count = 3, m_ready = 1 -> the three words appear in order, m_last on 0x33333333, done 7 cycles after start.
REQ-035 Same burst with m_ready low for 5 cycles on word 2 -> m_data stays 0x22222222, R_en stays low, and no word is lost or duplicated.
REQ-036 word_count = 0 -> no R_en, done pulses 1 cycle after start, busy high for exactly 1 cycle.
REQ-037 base_addr = 0xFFFFFFFE, word_count = 2 -> ram_addr = 0xFFFFFFFC, then 0x00000000.
REQ-038 rst pulsed while in HOLD with word 1 of 4 pending -> all outputs return to reset values next cycle, no done pulse; a new start with word_count = 1 completes normally.
REQ-039 start pulsed again mid-burst with a different base_addr -> ignored; the original address sequence continues.
